// File: rtl/fp_compare_pipe_if.sv
// Compare-unit request/result bundle.
// master = FPU issue side, slave = compare unit.
interface fp_compare_pipe_if #(
   parameter int NUM_CC = 8,
   parameter int CC_W   = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_cond;
   logic              in_double;
   logic [63:0]       in_a;
   logic [63:0]       in_b;
   logic [CC_W-1:0]   in_cc;
   logic              hold;
   logic              flush;
   logic              clr_invalid;
   logic              res_valid;
   logic              res_cond;
   logic [CC_W-1:0]   res_cc;
   logic              res_invalid;
   logic [NUM_CC-1:0] cc_out;
   logic              invalid_sticky;

   modport master (
      output in_valid, in_cond, in_double, in_a, in_b, in_cc,
      output hold, flush, clr_invalid,
      input  in_ready, res_valid, res_cond, res_cc, res_invalid,
      input  cc_out, invalid_sticky
   );

   modport slave (
      input  in_valid, in_cond, in_double, in_a, in_b, in_cc,
      input  hold, flush, clr_invalid,
      output in_ready, res_valid, res_cond, res_cc, res_invalid,
      output cc_out, invalid_sticky
   );
endinterface

// File: rtl/fp_compare_pipe.sv
// Two-stage IEEE-754 compare (c.cond.fmt) with FP condition-code bank
// and sticky invalid flag.
module fp_compare_pipe #(
   parameter int NUM_CC = 8,
   parameter int CC_W   = (NUM_CC > 1) ? $clog2(NUM_CC) : 1
) (
   input logic              clk,
   input logic              reset_n,
   fp_compare_pipe_if.slave bus
);
   logic        w_dbl;
   logic        w_accept;
   logic [62:0] w_a_mag;
   logic [62:0] w_b_mag;
   logic        w_a_sgn;
   logic        w_b_sgn;
   logic        w_a_eones;
   logic        w_b_eones;
   logic        w_a_mnz;
   logic        w_b_mnz;
   logic        w_a_mmsb;
   logic        w_b_mmsb;

   assign w_dbl    = bus.in_double;
   assign w_accept = bus.in_valid & bus.in_ready;

   // Single precision ignores the upper word entirely.
   assign w_a_mag   = w_dbl ? bus.in_a[62:0] : {32'd0, bus.in_a[30:0]};
   assign w_b_mag   = w_dbl ? bus.in_b[62:0] : {32'd0, bus.in_b[30:0]};
   assign w_a_sgn   = w_dbl ? bus.in_a[63] : bus.in_a[31];
   assign w_b_sgn   = w_dbl ? bus.in_b[63] : bus.in_b[31];
   assign w_a_eones = w_dbl ? &bus.in_a[62:52] : &bus.in_a[30:23];
   assign w_b_eones = w_dbl ? &bus.in_b[62:52] : &bus.in_b[30:23];
   assign w_a_mnz   = w_dbl ? |bus.in_a[51:0] : |bus.in_a[22:0];
   assign w_b_mnz   = w_dbl ? |bus.in_b[51:0] : |bus.in_b[22:0];
   assign w_a_mmsb  = w_dbl ? bus.in_a[51] : bus.in_a[22];
   assign w_b_mmsb  = w_dbl ? bus.in_b[51] : bus.in_b[22];

   logic            r_s1_valid;
   logic            r_a_sgn;
   logic            r_b_sgn;
   logic            r_a_eones;
   logic            r_b_eones;
   logic            r_a_mnz;
   logic            r_b_mnz;
   logic            r_a_mmsb;
   logic            r_b_mmsb;
   logic            r_a_zero;
   logic            r_b_zero;
   logic            r_mag_lt;
   logic            r_mag_eq;
   logic [3:0]      r_s1_cond;
   logic [CC_W-1:0] r_s1_cc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid <= 1'b0;
         r_a_sgn    <= 1'b0;
         r_b_sgn    <= 1'b0;
         r_a_eones  <= 1'b0;
         r_b_eones  <= 1'b0;
         r_a_mnz    <= 1'b0;
         r_b_mnz    <= 1'b0;
         r_a_mmsb   <= 1'b0;
         r_b_mmsb   <= 1'b0;
         r_a_zero   <= 1'b0;
         r_b_zero   <= 1'b0;
         r_mag_lt   <= 1'b0;
         r_mag_eq   <= 1'b0;
         r_s1_cond  <= 4'd0;
         r_s1_cc    <= '0;
      end else if (bus.flush) begin
         r_s1_valid <= 1'b0;
      end else if (!bus.hold) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_a_sgn   <= w_a_sgn;
            r_b_sgn   <= w_b_sgn;
            r_a_eones <= w_a_eones;
            r_b_eones <= w_b_eones;
            r_a_mnz   <= w_a_mnz;
            r_b_mnz   <= w_b_mnz;
            r_a_mmsb  <= w_a_mmsb;
            r_b_mmsb  <= w_b_mmsb;
            r_a_zero  <= (w_a_mag == 63'd0);
            r_b_zero  <= (w_b_mag == 63'd0);
            r_mag_lt  <= (w_a_mag < w_b_mag);
            r_mag_eq  <= (w_a_mag == w_b_mag);
            r_s1_cond <= bus.in_cond;
            r_s1_cc   <= bus.in_cc;
         end
      end
   end

   logic w_a_nan;
   logic w_b_nan;
   logic w_a_snan;
   logic w_b_snan;
   logic w_un;
   logic w_eq;
   logic w_lt_raw;
   logic w_lt;
   logic w_res_cond;
   logic w_res_inv;

   assign w_a_nan  = r_a_eones & r_a_mnz;
   assign w_b_nan  = r_b_eones & r_b_mnz;
   assign w_a_snan = w_a_nan & ~r_a_mmsb;
   assign w_b_snan = w_b_nan & ~r_b_mmsb;
   assign w_un     = w_a_nan | w_b_nan;
   // +0 and -0 compare equal despite differing sign bits.
   assign w_eq     = ~w_un & ((r_mag_eq & (r_a_sgn == r_b_sgn))
                             | (r_a_zero & r_b_zero));

   always_comb begin
      w_lt_raw = 1'b0;
      if (r_a_sgn != r_b_sgn)
         w_lt_raw = r_a_sgn;
      else if (!r_a_sgn)
         w_lt_raw = r_mag_lt;
      else
         w_lt_raw = ~r_mag_lt & ~r_mag_eq;
   end

   assign w_lt       = ~w_un & ~w_eq & w_lt_raw;
   assign w_res_cond = (r_s1_cond[2] & w_lt) | (r_s1_cond[1] & w_eq)
                     | (r_s1_cond[0] & w_un);
   assign w_res_inv  = w_a_snan | w_b_snan | (r_s1_cond[3] & w_un);

   logic            r_s2_valid;
   logic            r_res_cond;
   logic            r_res_inv;
   logic [CC_W-1:0] r_res_cc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s2_valid <= 1'b0;
         r_res_cond <= 1'b0;
         r_res_inv  <= 1'b0;
         r_res_cc   <= '0;
      end else if (bus.flush) begin
         r_s2_valid <= 1'b0;
      end else if (!bus.hold) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_res_cond <= w_res_cond;
            r_res_inv  <= w_res_inv;
            r_res_cc   <= r_s1_cc;
         end
      end
   end

   logic              w_commit;
   logic [NUM_CC-1:0] r_cc;
   logic              r_sticky;

   assign w_commit = r_s2_valid & ~bus.hold & ~bus.flush;

   // Indices past NUM_CC match no bit and so write nothing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cc     <= '0;
         r_sticky <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CC; i++)
            if (w_commit && (r_res_cc == CC_W'(i)))
               r_cc[i] <= r_res_cond;
         if (bus.clr_invalid)
            r_sticky <= 1'b0;
         else if (w_commit && r_res_inv)
            r_sticky <= 1'b1;
      end
   end

   assign bus.in_ready       = reset_n & ~bus.hold & ~bus.flush;
   assign bus.res_valid      = r_s2_valid;
   assign bus.res_cond       = r_res_cond;
   assign bus.res_cc         = r_res_cc;
   assign bus.res_invalid    = r_res_inv;
   assign bus.cc_out         = r_cc;
   assign bus.invalid_sticky = r_sticky;
endmodule

// File: tb/tb_fp_compare_pipe.sv
// Bench for fp_compare_pipe: directed cases plus random traffic,
// scored against a real-valued reference model.
module tb_fp_compare_pipe;
   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   fp_compare_pipe_if #(.NUM_CC(8), .CC_W(3)) bus ();

   fp_compare_pipe #(.NUM_CC(8), .CC_W(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       inv;
      logic [2:0] cc;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   logic [7:0] m_cc;
   logic       m_st;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   function automatic void classify(input logic [63:0] x, input bit dbl,
                                    output bit nan, output bit snan,
                                    output real v);
      int          e;
      logic [22:0] m;
      if (dbl) begin
         nan  = (x[62:52] == 11'h7FF) && (x[51:0] != 0);
         snan = nan && !x[51];
         v    = nan ? 0.0 : $bitstoreal(x);
      end else begin
         e    = int'(x[30:23]);
         m    = x[22:0];
         nan  = (e == 255) && (m != 0);
         snan = nan && !m[22];
         if (e == 255)    v = 1.0e300;
         else if (e == 0) v = real'(m) * (2.0 ** (-149));
         else             v = (1.0 + real'(m) / 8388608.0) * (2.0 ** (e - 127));
         if (x[31]) v = -v;
      end
   endfunction

   function automatic void ref_cmp(input logic [63:0] a, input logic [63:0] b,
                                   input bit dbl, input logic [3:0] cond,
                                   output bit r, output bit inv);
      bit  an, as, bn, bs, un, lt, eq;
      real va, vb;
      classify(a, dbl, an, as, va);
      classify(b, dbl, bn, bs, vb);
      un  = an | bn;
      lt  = !un && (va < vb);
      eq  = !un && (va == vb);
      r   = (cond[2] & lt) | (cond[1] & eq) | (cond[0] & un);
      inv = as | bs | (cond[3] & un);
   endfunction

   function automatic logic [63:0] rnd_op(input bit dbl);
      logic [63:0] x;
      int          k;
      x = {$urandom, $urandom};
      k = $urandom_range(0, 7);
      if (dbl) begin
         case (k)
            0: x[62:0]  = '0;
            1: x[62:0]  = {11'h7FF, 52'd0};
            2: x[62:52] = 11'h7FF;
            3: x[62:52] = 11'h3FE + 11'($urandom_range(0, 2));
            4: x[62:52] = '0;
            default: ;
         endcase
      end else begin
         case (k)
            0: x[30:0]  = '0;
            1: x[30:0]  = {8'hFF, 23'd0};
            2: x[30:23] = 8'hFF;
            3: x[30:23] = 8'h7E + 8'($urandom_range(0, 2));
            4: x[30:23] = '0;
            default: ;
         endcase
      end
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [63:0] a, input logic [63:0] b,
                        input bit dbl, input logic [3:0] cond,
                        input logic [2:0] cc);
      exp_t e;
      bit   r, inv;
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_double = dbl;
      bus.in_cond   = cond;
      bus.in_cc     = cc;
      if (!bus.hold && !bus.flush) begin
         ref_cmp(a, b, dbl, cond, r, inv);
         e.r   = r;
         e.inv = inv;
         e.cc  = cc;
         q.push_back(e);
      end
   endtask

   task automatic do1(input string nm, input logic [63:0] a,
                      input logic [63:0] b, input bit dbl,
                      input logic [3:0] cond, input logic [2:0] cc,
                      input bit req_r, input bit req_inv, input bit clr);
      issue(a, b, dbl, cond, cc);
      tick();
      bus.in_valid = 1'b0;
      tick();
      if (clr) bus.clr_invalid = 1'b1;
      @(negedge clk);
      chk({nm, "_valid"}, bus.res_valid, 1);
      chk({nm, "_cond"}, bus.res_cond, req_r);
      chk({nm, "_inv"}, bus.res_invalid, req_inv);
      tick();
      bus.clr_invalid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         q.delete();
         m_cc = '0;
         m_st = 1'b0;
      end else begin
         chk("cc_out", bus.cc_out, m_cc);
         chk("sticky", bus.invalid_sticky, m_st);
         if (bus.res_valid && !bus.hold && !bus.flush) begin
            if (q.size() == 0) begin
               chk("spurious_result", 1, 0);
            end else begin
               mon_e = q.pop_front();
               chk("sb_cond", bus.res_cond, mon_e.r);
               chk("sb_inv", bus.res_invalid, mon_e.inv);
               chk("sb_cc", bus.res_cc, mon_e.cc);
               m_cc[mon_e.cc] = mon_e.r;
               if (mon_e.inv) m_st = 1'b1;
            end
         end
         if (bus.flush) q.delete();
         if (bus.clr_invalid) m_st = 1'b0;
      end
   end

   initial begin
      logic [63:0] a, b;
      bit          dbl;
      int          sb;
      checks          = 0;
      failures        = 0;
      reset_n         = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_a        = '0;
      bus.in_b        = '0;
      bus.in_double   = 1'b0;
      bus.in_cond     = '0;
      bus.in_cc       = '0;
      bus.hold        = 1'b0;
      bus.flush       = 1'b0;
      bus.clr_invalid = 1'b0;
      tick();
      tick();
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_valid", bus.res_valid, 0);
      chk("rst_cc", bus.cc_out, 0);
      chk("rst_res", {bus.res_cond, bus.res_invalid, bus.res_cc}, 0);
      reset_n = 1'b1;
      #1;
      chk("post_rst_ready", bus.in_ready, 1);

      do1("le", 64'h3F800000, 64'h40000000, 0, 4'h6, 3, 1, 0, 0);
      chk("le_cc", bus.cc_out, 8'h08);
      do1("eq", 64'h3F800000, 64'h40000000, 0, 4'h2, 3, 0, 0, 0);
      chk("eq_cc", bus.cc_out, 8'h00);
      do1("zero", 64'h80000000, 64'h00000000, 0, 4'h2, 0, 1, 0, 0);
      do1("qnan_un", 64'h7FC00000, 64'h3F800000, 0, 4'h1, 1, 1, 0, 0);
      chk("qnan_sticky", bus.invalid_sticky, 0);
      do1("qnan_sf", 64'h7FC00000, 64'h3F800000, 0, 4'h9, 1, 1, 1, 0);
      chk("sf_sticky", bus.invalid_sticky, 1);
      do1("dbl_lt", 64'hC004000000000000, 64'h3FF0000000000000, 1, 4'h4, 2, 1, 0, 0);
      do1("dbl_neg", 64'hC004000000000000, 64'hC008000000000000, 1, 4'h4, 2, 0, 0, 0);
      do1("garbage", 64'hDEADBEEF3F800000, 64'h123456783F800000, 0, 4'h2, 2, 1, 0, 0);
      do1("snan", 64'h7F800001, 64'h3F800000, 0, 4'h0, 0, 0, 1, 1);
      chk("snan_clr", bus.invalid_sticky, 0);

      issue(64'h3F800000, 64'h40000000, 0, 4'h4, 0);
      tick();
      issue(64'h3F800000, 64'h40000000, 0, 4'h2, 1);
      tick();
      issue(64'h3F800000, 64'h40000000, 0, 4'h4, 2);
      tick();
      issue(64'h3F800000, 64'h40000000, 0, 4'h4, 3);
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("stream_cc", bus.cc_out[3:0], 4'hD);

      issue(64'h3F800000, 64'h40000000, 0, 4'h4, 1);
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_cc", bus.cc_out[3:0], 4'hD);
         chk("hold_valid", bus.res_valid, 1);
      end
      bus.hold = 1'b0;
      tick();
      chk("hold_commit", bus.cc_out[3:0], 4'hF);
      tick();
      chk("hold_once", bus.res_valid, 0);

      issue(64'h40000000, 64'h3F800000, 0, 4'h4, 1);
      tick();
      issue(64'h40000000, 64'h3F800000, 0, 4'h4, 2);
      tick();
      bus.in_valid = 1'b0;
      bus.flush    = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_cc", bus.cc_out[3:0], 4'hF);
      @(negedge clk);
      chk("flush_valid", bus.res_valid, 0);
      tick();
      tick();
      chk("flush_cc2", bus.cc_out[3:0], 4'hF);

      issue(64'h40000000, 64'h3F800000, 0, 4'h4, 0);
      tick();
      issue(64'h40000000, 64'h3F800000, 0, 4'h4, 3);
      tick();
      bus.in_valid = 1'b0;
      reset_n      = 1'b0;
      #1;
      chk("mid_rst_cc", bus.cc_out, 0);
      tick();
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", bus.in_ready, 1);
      tick();
      tick();
      tick();
      chk("mid_rst_nocommit", bus.cc_out, 0);
      chk("mid_rst_valid", bus.res_valid, 0);

      for (int n = 0; n < 1500; n++) begin
         bus.hold        = ($urandom_range(0, 9) == 0);
         bus.flush       = ($urandom_range(0, 29) == 0);
         bus.clr_invalid = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 3) != 0) begin
            dbl = $urandom_range(0, 1) == 1;
            a   = rnd_op(dbl);
            sb  = $urandom_range(0, 9);
            if (sb < 3)       b = a;
            else if (sb == 3) b = dbl ? (a ^ 64'h8000000000000000) : (a ^ 64'h80000000);
            else              b = rnd_op(dbl);
            issue(a, b, dbl, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
         end else begin
            bus.in_valid = 1'b0;
         end
         tick();
      end
      bus.in_valid    = 1'b0;
      bus.hold        = 1'b0;
      bus.flush       = 1'b0;
      bus.clr_invalid = 1'b0;
      for (int n = 0; n < 10 && q.size() != 0; n++) tick();
      chk("drain_empty", 64'(q.size()), 0);
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
